mole_timer_bank: RTL
====================

# mole_timer_bank

Multi-channel mole visibility timer for the whack-a-mole game core. It holds one down-counter per mole hole, which the game FSM arms with a start pulse. Each channel counts only while the game is in play and its own enable is high, and it raises a one-cycle expire pulse when its interval elapses. A shared, level-adjustable period register shortens mole visibility as the player advances.

## Interface
Parameters:
- CHANNELS, 4, number of independent mole timers
- WIDTH, 25, counter and period width in bits
- BASE_PERIOD, 25000000, period after reset or level_reset, in enabled cycles (0.5 s at 50 MHz); must satisfy BASE_PERIOD < 2^WIDTH
- MIN_PERIOD, 5000000, floor for the period; must satisfy 1 <= MIN_PERIOD <= BASE_PERIOD
- STEP, 2500000, amount the period decreases per level_up

Ports:
- clock  in  1  system clock; all logic is on the rising edge
- resetn  in  1  reset, asynchronous, active-low
- play  in  1  global run qualifier; all counters freeze while low
- enable  in  CHANNELS  per-channel count qualifier
- start  in  CHANNELS  per-channel pulse that loads period-1 and arms the channel
- stop  in  CHANNELS  per-channel pulse that disarms the channel
- autoreload  in  CHANNELS  per-channel mode: 1 reloads on expiry, 0 runs one-shot
- level_up  in  1  pulse that decreases the period by STEP, saturating at MIN_PERIOD
- level_reset  in  1  pulse that restores the period to BASE_PERIOD
- expire  out  CHANNELS  registered one-cycle expiry pulse per channel
- active  out  CHANNELS  channel is in RUN
- count  out  CHANNELS*WIDTH  current count per channel; channel i occupies bits [i*WIDTH +: WIDTH]
- period  out  WIDTH  current shared period register

## Operation
- Reset values: period=BASE_PERIOD; every count=0; every channel IDLE; active=0; expire=0.
- Per-channel states: IDLE and RUN. `active` is high exactly when the channel is in RUN.
- A channel is "tick-eligible" in a cycle when it is in RUN and play && enable[i].
- Per-channel priority each cycle (highest first):
  1. start[i]: count <= period-1, state RUN, expire[i] <= 0.
  2. stop[i]: count <= 0, state IDLE, expire[i] <= 0.
  3. Tick-eligible with count==0: expire[i] <= 1.
     - If autoreload[i]: count <= period-1, stay in RUN.
     - Otherwise: count stays 0, state IDLE.
  4. Tick-eligible with count!=0: count <= count-1, expire[i] <= 0.
  5. Otherwise: hold count and state, expire[i] <= 0.
- start applied to a channel already in RUN restarts it.
- A start in the same cycle as that channel's expiry suppresses the expire pulse.
- Period update each cycle:
  - level_reset: period <= BASE_PERIOD. level_reset beats level_up when both are high.
  - level_up: period <= (period - STEP < MIN_PERIOD) ? MIN_PERIOD : period - STEP.
  - The comparison is computed in WIDTH+1 bits so the subtraction cannot underflow.
- A start or autoreload uses the period register value before that edge. A period change therefore applies only to loads that occur after the change and never to running counts.
- A channel in IDLE ignores enable, play and autoreload.
- Channels are fully independent except for the shared period.

## Timing
- With a start at edge 0, period P, and continuous tick-eligibility:
  - count = P-1 after edge 0.
  - count = 0 after edge P-1.
  - expire is high for the single cycle after edge P.
  - The latency from start to expire is exactly P cycles.
- With autoreload, expire repeats every P eligible cycles with no gap cycle.
- Cycles in which play or enable[i] is low stretch the interval 1:1. The count holds and is not lost.
- play falling while count==0 in RUN: no expire until play returns. The expire then occurs on the first eligible cycle.
- Asynchronous reset mid-count: all outputs take their reset values immediately. Counting resumes only after a new start.
- Outputs are registered, with no combinational path from inputs to outputs.

## Test plan
All scenarios use CHANNELS=2, WIDTH=8, BASE_PERIOD=10, MIN_PERIOD=4, STEP=3.
- Reset, then start[0] with play=1, enable=11, autoreload=00 -> expire[0] pulses exactly 10 cycles after start, then active[0]=0 and count0=0; channel 1 stays idle.
- Autoreload=01, start[0], run 35 cycles -> expire[0] at cycles 10, 20 and 30, each one cycle wide; count0 sequence 9..0,9.
- Pause: start[1], drop play for 5 cycles at count1=6 -> count1 holds at 6; expire[1] arrives at cycle 15; toggling enable[1] gives the same stretching.
- level_up pulsed 3 times -> period 7, 4, 4 (saturated); level_up and level_reset in the same cycle -> 10; a start issued in the level_up cycle loads the old period-1.
- start[0] asserted in the cycle count0==0 and tick-eligible -> no expire, count0=9; stop[0] mid-count -> active[0]=0, count0=0, no expire.
- resetn asserted low asynchronously between edges mid-count -> count, active and expire all 0 immediately and period=10.

Source files
------------

// File: rtl/mole_timer_bank.sv
// Bank of per-hole mole visibility down-counters sharing one level-adjustable period.
// Each channel is armed by start, counts while play and its enable are high, and pulses expire on elapse.
module mole_timer_bank #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 25,
    parameter int BASE_PERIOD = 25000000,
    parameter int MIN_PERIOD  = 5000000,
    parameter int STEP        = 2500000
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      play,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       stop,
    input  logic [CHANNELS-1:0]       autoreload,
    input  logic                      level_up,
    input  logic                      level_reset,
    output logic [CHANNELS-1:0]       expire,
    output logic [CHANNELS-1:0]       active,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [WIDTH-1:0]          period
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [WIDTH-1:0] BASE_W = WIDTH'(BASE_PERIOD);
    localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN_PERIOD);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_W = WIDTH'(0);
    // period - STEP < MIN  <=>  period < MIN + STEP, evaluated one bit wider so it cannot wrap
    localparam logic [WIDTH:0]   FLOOR_W = {1'b0, MIN_W} + {1'b0, STEP_W};

    logic [WIDTH-1:0] period_r;
    logic [WIDTH-1:0] period_next_s;
    logic [WIDTH-1:0] reload_s;

    // Value loaded by start/autoreload, always taken from the pre-edge period
    assign reload_s = period_r - ONE_W;
    assign period   = period_r;

    // Next shared period: level_reset wins over level_up; level_up saturates at the floor
    always_comb begin
        period_next_s = period_r;
        if (level_reset) begin
            period_next_s = BASE_W;
        end else if (level_up) begin
            if ({1'b0, period_r} < FLOOR_W) begin
                period_next_s = MIN_W;
            end else begin
                period_next_s = period_r - STEP_W;
            end
        end else begin
            period_next_s = period_r;
        end
    end

    // Shared period register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            period_r <= BASE_W;
        end else begin
            period_r <= period_next_s;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic [0:0]       state_r;
        logic [0:0]       state_next_s;
        logic [WIDTH-1:0] count_r;
        logic [WIDTH-1:0] count_next_s;
        logic             expire_r;
        logic             expire_next_s;
        logic             tick_s;

        assign tick_s = (state_r == ST_RUN) && play && enable[g];

        // Per-channel next state in priority order: start, stop, expiry, decrement, hold
        always_comb begin
            state_next_s  = state_r;
            count_next_s  = count_r;
            expire_next_s = 1'b0;
            if (start[g]) begin
                state_next_s = ST_RUN;
                count_next_s = reload_s;
            end else if (stop[g]) begin
                state_next_s = ST_IDLE;
                count_next_s = ZERO_W;
            end else if (tick_s && (count_r == ZERO_W)) begin
                expire_next_s = 1'b1;
                if (autoreload[g]) begin
                    state_next_s = ST_RUN;
                    count_next_s = reload_s;
                end else begin
                    state_next_s = ST_IDLE;
                    count_next_s = ZERO_W;
                end
            end else if (tick_s) begin
                count_next_s = count_r - ONE_W;
            end else begin
                state_next_s = state_r;
                count_next_s = count_r;
            end
        end

        // Per-channel state, count and expire pulse registers
        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                state_r  <= ST_IDLE;
                count_r  <= ZERO_W;
                expire_r <= 1'b0;
            end else begin
                state_r  <= state_next_s;
                count_r  <= count_next_s;
                expire_r <= expire_next_s;
            end
        end

        assign expire[g]                  = expire_r;
        assign active[g]                  = (state_r == ST_RUN);
        assign count[g*WIDTH +: WIDTH]    = count_r;
    end

endmodule
